csa_mult_seq: RTL and testbench

//  Iterative unsigned multiplier that time-shares a single 64-bit carry-save adder (csa64).
//  One multiplier bit is folded into a redundant sum/carry pair per cycle, then one final

---
 rtl/mult_pkg.sv | 11 +
 rtl/csa_mult_seq_if.sv | 23 ++
 rtl/csa64.sv | 11 +
 rtl/csa_mult_seq.sv | 100 ++++++++++
 tb/tb_csa_mult_seq.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types for the sequential carry-save multiplier: FSM state encoding and adder width.
package mult_pkg;
  localparam int CSA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COMP = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/csa_mult_seq_if.sv
// Operand/product valid-ready bundle for csa_mult_seq; slave is the multiplier side.
interface csa_mult_seq_if #(
  parameter int N = 32
) ();
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] p;
  logic           busy;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, busy
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/csa64.sv
// 64-bit 3:2 carry-save adder; carry comes out pre-shifted, the top carry-out is dropped.
module csa64 (
  input  logic [63:0] i_x,
  input  logic [63:0] i_y,
  input  logic [63:0] i_z,
  output logic [63:0] o_s,
  output logic [63:0] o_c
);
  assign o_s = i_x ^ i_y ^ i_z;
  assign o_c = {(i_x[62:0] & i_y[62:0]) | (i_x[62:0] & i_z[62:0]) | (i_y[62:0] & i_z[62:0]), 1'b0};
endmodule

// File: rtl/csa_mult_seq.sv
// Iterative unsigned multiplier: one multiplier bit folded per cycle into a sum/carry pair
// through a single shared csa64, then one carry-propagate add. Fixed latency, no bit skipping.
module csa_mult_seq
  import mult_pkg::*;
#(
  parameter int N = 32
) (
  input  logic          clk,
  input  logic          rst,
  csa_mult_seq_if.slave bus
);
  localparam int CNT_W = $clog2(N);

  state_t            r_state;
  state_t            w_next;
  logic [N-1:0]      r_a;
  logic [N-1:0]      r_b;
  logic [CSA_W-1:0]  r_sum;
  logic [CSA_W-1:0]  r_carry;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*N-1:0]    r_p;
  logic [CSA_W-1:0]  w_pp;
  logic [CSA_W-1:0]  w_s;
  logic [CSA_W-1:0]  w_c;
  logic [CSA_W-1:0]  w_final;
  logic              w_last;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_busy;

  assign w_last  = (r_cnt == CNT_W'(N - 1));
  assign w_pp    = r_b[r_cnt] ? ({{(CSA_W - N){1'b0}}, r_a} << r_cnt) : '0;
  assign w_final = r_sum + r_carry;

  csa64 u_csa (
    .i_x (r_sum),
    .i_y (r_carry),
    .i_z (w_pp),
    .o_s (w_s),
    .o_c (w_c)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.in_valid)  w_next = COMP;
      COMP:    if (w_last)        w_next = ADD;
      ADD:                        w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default:                    w_next = IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = (r_state == IDLE);
    w_out_valid = (r_state == DONE);
    w_busy      = (r_state == COMP) || (r_state == ADD);
  end

  // Datapath; operands are only sampled in IDLE so they may change right after accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_sum   <= '0;
            r_carry <= '0;
            r_cnt   <= '0;
          end
        end
        COMP: begin
          r_sum   <= w_s;
          r_carry <= w_c;
          r_cnt   <= r_cnt + 1'b1;
        end
        ADD:     r_p <= w_final[2*N-1:0];
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.p         = r_p;
endmodule

// File: tb/tb_csa_mult_seq.sv
// Self-checking bench: transaction-level model of both an N=32 and an N=8 multiplier,
// directed latency/backpressure/reset cases on N=32 and random traffic on N=8.
module tb_csa_mult_seq;
  localparam int N32 = 32;
  localparam int N8  = 8;

  logic clk = 1'b0;
  logic rst32;
  logic rst8;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  csa_mult_seq_if #(.N(N32)) if32 ();
  csa_mult_seq_if #(.N(N8))  if8 ();

  csa_mult_seq #(.N(N32)) u_dut32 (.clk(clk), .rst(rst32), .bus(if32));
  csa_mult_seq #(.N(N8))  u_dut8  (.clk(clk), .rst(rst8),  .bus(if8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state per instance: an op is pending from its accept edge until its retire edge.
  bit          known [2];
  bit          pend  [2];
  int          acc   [2];
  logic [63:0] exp_p [2];
  logic [63:0] last_p[2];
  int          done_cnt[2];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endfunction

  task automatic model_step(input int id, input int n, input string tag, input logic rst_i,
                            input logic in_valid, input logic out_ready, input logic in_ready,
                            input logic out_valid, input logic busy, input logic [63:0] p,
                            input logic [63:0] a_in, input logic [63:0] b_in);
    int d;
    if (known[id]) begin
      if (!pend[id]) begin
        chk({tag, "_idle_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_idle_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
        chk({tag, "_idle_p"}, p, last_p[id]);
      end else begin
        d = cyc - acc[id];
        chk({tag, "_op_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_op_busy"}, 64'(busy), 64'(d <= n));
        chk({tag, "_op_out_valid"}, 64'(out_valid), 64'(d >= n + 1));
        chk({tag, "_op_p"}, p, (d >= n + 1) ? exp_p[id] : last_p[id]);
      end
    end
    if (rst_i) begin
      pend[id]   = 1'b0;
      last_p[id] = '0;
      known[id]  = 1'b1;
    end else if (known[id]) begin
      if (!pend[id] && in_valid) begin
        pend[id]  = 1'b1;
        acc[id]   = cyc + 1;
        exp_p[id] = a_in * b_in;
      end else if (pend[id] && (cyc - acc[id] >= n + 1) && out_ready) begin
        pend[id]   = 1'b0;
        last_p[id] = exp_p[id];
        done_cnt[id]++;
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0, N32, "m32", rst32, if32.in_valid, if32.out_ready, if32.in_ready,
               if32.out_valid, if32.busy, if32.p, 64'(if32.a), 64'(if32.b));
    model_step(1, N8, "m8", rst8, if8.in_valid, if8.out_ready, if8.in_ready,
               if8.out_valid, if8.busy, 64'(if8.p), 64'(if8.a), 64'(if8.b));
  end

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input int stall,
                       input logic [63:0] expv, input string tag);
    int lat;
    logic [63:0] p0;
    @(posedge clk); #1;
    if32.a = a; if32.b = b; if32.in_valid = 1'b1; if32.out_ready = 1'b0;
    @(posedge clk); #1;
    if32.in_valid = 1'b0; if32.a = $urandom; if32.b = $urandom;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (if32.out_valid) break;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(N32 + 2));
    chk({tag, "_p"}, if32.p, expv);
    p0 = if32.p;
    repeat (stall) begin
      @(negedge clk);
      chk({tag, "_hold_p"}, if32.p, p0);
      chk({tag, "_hold_out_valid"}, 64'(if32.out_valid), 64'd1);
      chk({tag, "_hold_in_ready"}, 64'(if32.in_ready), 64'd0);
    end
    @(posedge clk); #1 if32.out_ready = 1'b1;
    @(posedge clk); #1 if32.out_ready = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev_acc;
    int n_acc;
    int cycles;
    rst32 = 1'b1; rst8 = 1'b1;
    if32.in_valid = 1'b0; if32.out_ready = 1'b0; if32.a = '0; if32.b = '0;
    if8.in_valid  = 1'b0; if8.out_ready  = 1'b0; if8.a  = '0; if8.b  = '0;
    repeat (3) @(posedge clk);
    #1 rst32 = 1'b0; rst8 = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 64'(if32.in_ready), 64'd1);
    chk("reset_out_valid", 64'(if32.out_valid), 64'd0);
    chk("reset_busy", 64'(if32.busy), 64'd0);
    chk("reset_p", if32.p, 64'd0);

    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 64'hFFFF_FFFE_0000_0001, "max");
    run32(32'h1234, 32'h0, 0, 64'h0, "zero_b");
    run32(32'h0, 32'hDEAD_BEEF, 10, 64'h0, "zero_a_stall");
    run32(32'h1, 32'h8000_0000, 10, 64'h8000_0000, "msb_stall");
    run32(32'h0001_0003, 32'h0000_0005, 2, 64'h5_000F, "small");

    // Reset in the middle of COMP abandons the operation.
    @(posedge clk); #1;
    if32.a = 32'd77; if32.b = 32'd99; if32.in_valid = 1'b1;
    @(posedge clk); #1 if32.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst32 = 1'b1;
    @(posedge clk); #1 rst32 = 1'b0;
    repeat (40) begin
      @(negedge clk);
      chk("abort_no_out_valid", 64'(if32.out_valid), 64'd0);
    end
    run32(32'd3, 32'd5, 0, 64'd15, "rst_recover");

    // Back-to-back: operands always offered, consumer always ready.
    @(posedge clk); #1;
    if32.a = $urandom; if32.b = $urandom; if32.in_valid = 1'b1; if32.out_ready = 1'b1;
    n_acc = 0; prev_acc = 0; cycles = 0;
    while (n_acc < 5 && cycles < 400) begin
      @(negedge clk);
      cycles++;
      if (if32.in_ready && if32.in_valid) begin
        if (n_acc > 0) chk("b2b_spacing", 64'(cyc + 1 - prev_acc), 64'(N32 + 3));
        prev_acc = cyc + 1;
        n_acc++;
        @(posedge clk); #1;
        if32.a = $urandom; if32.b = $urandom;
      end
    end
    chk("b2b_accepts", 64'(n_acc), 64'd5);
    if32.in_valid = 1'b0;
    repeat (N32 + 5) @(posedge clk);
    chk("b2b_all_retired", 64'(pend[0]), 64'd0);

    // Random traffic on the N=8 instance.
    cycles = 0;
    while (done_cnt[1] < 1000 && cycles < 60000) begin
      @(posedge clk); #1;
      cycles++;
      if8.in_valid  = ($urandom_range(0, 3) != 0);
      if8.a         = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom);
      if8.b         = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom);
      if8.out_ready = ($urandom_range(0, 2) != 0);
    end
    chk("n8_ops_done", 64'(done_cnt[1] >= 1000), 64'd1);
    if8.in_valid = 1'b0; if8.out_ready = 1'b1;
    repeat (20) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
